// File: rtl/occupancy_counter.sv
// rtl/occupancy_counter.sv - bidirectional doorway occupancy counter with per-door filtering
module occupancy_counter #(
    parameter int NUM_DOORS = 2,
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 15,
    parameter int FILTER    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_DOORS-1:0] sens_a,
    input  logic [NUM_DOORS-1:0] sens_b,
    output logic [WIDTH-1:0]     count,
    output logic                 full,
    output logic                 empty,
    output logic [NUM_DOORS-1:0] entry_evt,
    output logic [NUM_DOORS-1:0] exit_evt,
    output logic                 sat_err
);

    localparam int CW = $clog2(FILTER + 1);
    localparam int SW = WIDTH + 4;
    localparam logic signed [SW-1:0] MAX_S = SW'(MAX_COUNT);

    typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} door_state_t;

    // Pairs are packed as {a, b}
    logic [1:0]          sync1 [NUM_DOORS];
    logic [1:0]          sync2 [NUM_DOORS];
    logic [1:0]          acc   [NUM_DOORS];
    logic [CW-1:0]       stab  [NUM_DOORS];
    logic [CW:0]         run   [NUM_DOORS];
    logic [NUM_DOORS-1:0] stable;
    logic [NUM_DOORS-1:0] acc_upd;

    door_state_t          state_q [NUM_DOORS];
    door_state_t          state_d [NUM_DOORS];
    logic [NUM_DOORS-1:0] entry_d;
    logic [NUM_DOORS-1:0] exit_d;

    logic signed [SW-1:0] net;
    logic signed [SW-1:0] sum;
    logic [WIDTH-1:0]     next_count;
    logic                 clip;

    // Two-flop synchroniser on every raw sensor bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < NUM_DOORS; d++) begin
                sync1[d] <= 2'b00;
                sync2[d] <= 2'b00;
            end
        end else begin
            for (int d = 0; d < NUM_DOORS; d++) begin
                sync1[d] <= {sens_a[d], sens_b[d]};
                sync2[d] <= sync1[d];
            end
        end
    end

    // A pair counts as stable when the next synchronised sample already matches it,
    // so a change is accepted FILTER cycles after it appears at the synchroniser output
    always_comb begin
        for (int d = 0; d < NUM_DOORS; d++) begin
            run[d]    = {1'b0, stab[d]} + {{CW{1'b0}}, 1'b1};
            stable[d] = (sync1[d] == sync2[d]) && (sync2[d] != acc[d]);
        end
    end

    // Glitch filter: promote the synchronised pair once it has held long enough
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_upd <= '0;
            for (int d = 0; d < NUM_DOORS; d++) begin
                acc[d]  <= 2'b00;
                stab[d] <= '0;
            end
        end else begin
            for (int d = 0; d < NUM_DOORS; d++) begin
                acc_upd[d] <= 1'b0;
                if (!stable[d]) begin
                    stab[d] <= '0;
                end else if (run[d] >= (CW + 1)'(FILTER)) begin
                    acc[d]     <= sync2[d];
                    acc_upd[d] <= 1'b1;
                    stab[d]    <= '0;
                end else begin
                    stab[d] <= run[d][CW-1:0];
                end
            end
        end
    end

    // Door FSM state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < NUM_DOORS; d++) state_q[d] <= IDLE;
        end else begin
            for (int d = 0; d < NUM_DOORS; d++) state_q[d] <= state_d[d];
        end
    end

    // Direction decode; only reacts to a freshly accepted pair, anything unexpected aborts to IDLE
    always_comb begin
        for (int d = 0; d < NUM_DOORS; d++) begin
            state_d[d] = state_q[d];
            entry_d[d] = 1'b0;
            exit_d[d]  = 1'b0;
            if (acc_upd[d]) begin
                state_d[d] = IDLE;
                case (state_q[d])
                    IDLE: begin
                        if (acc[d] == 2'b10)      state_d[d] = EN1;
                        else if (acc[d] == 2'b01) state_d[d] = EX1;
                    end
                    EN1: if (acc[d] == 2'b11) state_d[d] = EN2;
                    EN2: begin
                        if (acc[d] == 2'b01)      state_d[d] = EN3;
                        else if (acc[d] == 2'b10) state_d[d] = EN1;
                    end
                    EN3: begin
                        if (acc[d] == 2'b00)      entry_d[d] = 1'b1;
                        else if (acc[d] == 2'b11) state_d[d] = EN2;
                    end
                    EX1: if (acc[d] == 2'b11) state_d[d] = EX2;
                    EX2: begin
                        if (acc[d] == 2'b10)      state_d[d] = EX3;
                        else if (acc[d] == 2'b01) state_d[d] = EX1;
                    end
                    EX3: begin
                        if (acc[d] == 2'b00)      exit_d[d] = 1'b1;
                        else if (acc[d] == 2'b11) state_d[d] = EX2;
                    end
                    default: state_d[d] = IDLE;
                endcase
            end
        end
    end

    // Net change across all doors, applied with clamping so opposing events cancel first
    always_comb begin
        net = '0;
        for (int d = 0; d < NUM_DOORS; d++) begin
            if (entry_d[d]) net = net + SW'(1);
            if (exit_d[d])  net = net - SW'(1);
        end
        sum  = $signed({4'b0000, count}) + net;
        clip = 1'b0;
        if (sum < 0) begin
            next_count = '0;
            clip       = 1'b1;
        end else if (sum > MAX_S) begin
            next_count = WIDTH'(MAX_COUNT);
            clip       = 1'b1;
        end else begin
            next_count = sum[WIDTH-1:0];
        end
    end

    // Registered outputs: count, flags and event pulses all update on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            sat_err   <= 1'b0;
            entry_evt <= '0;
            exit_evt  <= '0;
        end else begin
            count     <= next_count;
            full      <= (next_count == WIDTH'(MAX_COUNT));
            empty     <= (next_count == '0);
            sat_err   <= clip;
            entry_evt <= entry_d;
            exit_evt  <= exit_d;
        end
    end

endmodule

// File: tb/tb_occupancy_counter.sv
// tb/tb_occupancy_counter.sv - directed bench for occupancy_counter
module tb_occupancy_counter;

    localparam int ND = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [ND-1:0] sens_a = '0;
    logic [ND-1:0] sens_b = '0;
    logic [3:0]    count;
    logic          full;
    logic          empty;
    logic [ND-1:0] entry_evt;
    logic [ND-1:0] exit_evt;
    logic          sat_err;

    int checks = 0;
    int errors = 0;

    int ent0 = 0, ext0 = 0, ext1 = 0, sat_n = 0, ent_sat = 0, coinc = 0, peak = 0;

    occupancy_counter #(
        .NUM_DOORS(ND), .WIDTH(4), .MAX_COUNT(15), .FILTER(2)
    ) dut (
        .clk(clk), .rst(rst), .sens_a(sens_a), .sens_b(sens_b),
        .count(count), .full(full), .empty(empty),
        .entry_evt(entry_evt), .exit_evt(exit_evt), .sat_err(sat_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor sampled away from the active edge
    always @(negedge clk) begin
        if (entry_evt[0])             ent0    <= ent0 + 1;
        if (exit_evt[0])              ext0    <= ext0 + 1;
        if (exit_evt[1])              ext1    <= ext1 + 1;
        if (sat_err)                  sat_n   <= sat_n + 1;
        if (entry_evt[0] && sat_err)  ent_sat <= ent_sat + 1;
        if (entry_evt[0] && exit_evt[1]) coinc <= coinc + 1;
        if (int'(count) > peak)       peak    <= int'(count);
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set(input int d, input logic a, input logic b);
        sens_a[d] = a;
        sens_b[d] = b;
    endtask

    task automatic entry(input int d);
        set(d, 1, 0); cyc(6);
        set(d, 1, 1); cyc(6);
        set(d, 0, 1); cyc(6);
        set(d, 0, 0); cyc(6);
    endtask

    task automatic leave(input int d);
        set(d, 0, 1); cyc(6);
        set(d, 1, 1); cyc(6);
        set(d, 1, 0); cyc(6);
        set(d, 0, 0); cyc(6);
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(3);
        rst = 1'b0; cyc(2);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_empty"}, int'(empty), 1);
        check({tag, "_full"},  int'(full), 0);
        check({tag, "_sat"},   int'(sat_err), 0);
        check({tag, "_evts"},  int'({entry_evt, exit_evt}), 0);
    endtask

    initial begin
        int lat;
        int evt_at;
        int s_ent, s_ext, s_sat, s_es, s_co;

        // Reset state
        cyc(3);
        check_reset_vals("rst");
        rst = 1'b0; cyc(2);

        // Single entry with latency from final raw release
        set(0, 1, 0); cyc(6);
        set(0, 1, 1); cyc(6);
        set(0, 0, 1); cyc(6);
        check("e1_pre_empty", int'(empty), 1);
        set(0, 0, 0);
        lat = -1; evt_at = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (lat < 0 && count == 4'd1) begin
                lat = i;
                evt_at = int'(entry_evt[0]);
            end
        end
        check("e1_latency", lat, 5);
        check("e1_evt_with_count", evt_at, 1);
        check("e1_count", int'(count), 1);
        check("e1_empty", int'(empty), 0);
        check("e1_pulses", ent0, 1);

        // Seven entries then seven exits
        do_reset();
        s_ent = ent0; s_ext = ext0; s_sat = sat_n;
        for (int i = 0; i < 7; i++) entry(0);
        check("up7_count", int'(count), 7);
        for (int i = 0; i < 7; i++) leave(0);
        check("ud_peak", peak, 7);
        check("ud_count", int'(count), 0);
        check("ud_empty", int'(empty), 1);
        check("ud_entries", ent0 - s_ent, 7);
        check("ud_exits", ext0 - s_ext, 7);
        check("ud_sat", sat_n - s_sat, 0);

        // Saturation at MAX_COUNT
        do_reset();
        s_ent = ent0; s_sat = sat_n; s_es = ent_sat;
        for (int i = 0; i < 16; i++) entry(0);
        check("sat_count", int'(count), 15);
        check("sat_full", int'(full), 1);
        check("sat_entries", ent0 - s_ent, 16);
        check("sat_pulses", sat_n - s_sat, 1);
        check("sat_with_entry", ent_sat - s_es, 1);

        // Simultaneous entry on door 0 and exit on door 1 at full
        s_sat = sat_n; s_co = coinc;
        set(0, 1, 0); set(1, 0, 1); cyc(6);
        set(0, 1, 1); set(1, 1, 1); cyc(6);
        set(0, 0, 1); set(1, 1, 0); cyc(6);
        set(0, 0, 0); set(1, 0, 0); cyc(6);
        check("sim_count", int'(count), 15);
        check("sim_sat", sat_n - s_sat, 0);
        check("sim_coincident", coinc - s_co, 1);

        // One-cycle dropout on sens_a[1] while door 1 waits in EX3
        s_ext = ext1;
        set(1, 0, 1); cyc(6);
        set(1, 1, 1); cyc(6);
        set(1, 1, 0); cyc(6);
        set(1, 0, 0); cyc(1);
        set(1, 1, 0); cyc(8);
        check("glitch_exit", ext1 - s_ext, 0);
        check("glitch_count", int'(count), 15);
        set(1, 0, 0); cyc(6);
        check("glitch_then_exit", ext1 - s_ext, 1);
        check("glitch_then_count", int'(count), 14);

        // Exit from empty clips at zero
        do_reset();
        s_sat = sat_n; s_ext = ext0;
        leave(0);
        check("under_count", int'(count), 0);
        check("under_empty", int'(empty), 1);
        check("under_sat", sat_n - s_sat, 1);
        check("under_exit", ext0 - s_ext, 1);

        // Abort and backtrack sequences
        s_ent = ent0; s_ext = ext0;
        set(0, 1, 0); cyc(6); set(0, 1, 1); cyc(6);
        set(0, 1, 0); cyc(6); set(0, 0, 0); cyc(6);
        check("abort1_count", int'(count), 0);
        check("abort1_evts", (ent0 - s_ent) + (ext0 - s_ext), 0);
        set(0, 1, 0); cyc(6); set(0, 1, 1); cyc(6);
        set(0, 0, 1); cyc(6); set(0, 1, 1); cyc(6);
        set(0, 0, 1); cyc(6); set(0, 0, 0); cyc(6);
        check("backtrack_count", int'(count), 1);
        check("backtrack_entries", ent0 - s_ent, 1);
        set(0, 1, 0); cyc(6); set(0, 0, 1); cyc(6);
        set(0, 0, 0); cyc(6);
        check("jump_count", int'(count), 1);
        check("jump_entries", ent0 - s_ent, 1);
        check("jump_exits", ext0 - s_ext, 0);

        // Reset while door 0 sits in EN3
        set(0, 1, 0); cyc(6); set(0, 1, 1); cyc(6);
        set(0, 0, 1); cyc(6);
        s_ent = ent0;
        rst = 1'b1; cyc(2);
        check_reset_vals("midrst");
        rst = 1'b0;
        set(0, 0, 0); cyc(10);
        check("midrst_entries", ent0 - s_ent, 0);
        check("midrst_count", int'(count), 0);
        check("midrst_empty", int'(empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/occupancy_counter.md
# occupancy_counter

Parametrised bidirectional occupancy counter for NUM_DOORS doorways, each watched by an outer sensor A and an inner sensor B. Each door's raw sensor pair passes through a synchroniser and a glitch filter into a direction-decoding FSM. The FSM recognises the ordered sequences A, AB, B, none (entry) and B, AB, A, none (exit). A shared saturating counter accumulates the net occupancy, which the board drives onto LEDs or a display. Only complete sequences count; aborted or backtracked passages are discarded.

## Interface
- NUM_DOORS, 2, number of independent doorways (1..8)
- WIDTH, 4, counter width in bits
- MAX_COUNT, 15, capacity; must be ≤ 2^WIDTH−1
- FILTER, 2, consecutive stable cycles required before a synchronised sensor pair is accepted (≥1)

- CLK  in  1  system clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- SENS_A  in  NUM_DOORS  outer sensors, raw and asynchronous, 1 = beam broken
- SENS_B  in  NUM_DOORS  inner sensors, raw and asynchronous
- COUNT  out  WIDTH  current occupancy
- FULL  out  1  COUNT == MAX_COUNT
- EMPTY  out  1  COUNT == 0
- ENTRY_EVT  out  NUM_DOORS  one-cycle pulse per door on a completed entry
- EXIT_EVT  out  NUM_DOORS  one-cycle pulse per door on a completed exit
- SAT_ERR  out  1  one-cycle pulse when a net change was clipped at 0 or MAX_COUNT

## Operation
- **Reset:** COUNT=0, EMPTY=1, FULL=0, all pulses 0, every FSM in IDLE, synchroniser and filter registers set to 00.
- **Synchroniser:** two flops per raw bit.
- **Filter:** each door keeps an accepted pair {A,B} and a stability counter.
  - The counter increments while the synchronised pair is unchanged and differs from the accepted pair.
  - After FILTER consecutive equal cycles, the synchronised pair becomes the accepted pair.
  - Any change in the synchronised pair restarts the count.
- **Door FSM:** one per door. States are IDLE, EN1, EN2, EN3, EX1, EX2, EX3. Transitions are evaluated on accepted-pair changes only; the notation below is {A,B}.
  - IDLE: 10→EN1, 01→EX1, 11→IDLE (ambiguous, ignored).
  - EN1: 11→EN2, 00→IDLE.
  - EN2: 01→EN3, 10→EN1.
  - EN3: 00→IDLE and pulse ENTRY_EVT; 11→EN2.
  - EX1: 11→EX2, 00→IDLE.
  - EX2: 10→EX3, 01→EX1.
  - EX3: 00→IDLE and pulse EXIT_EVT; 11→EX2.
  - Any transition not listed (e.g. 00 from EN2/EX2, 10↔01 jump): return to IDLE with no event.
- **Accumulator:**
  - Each cycle: net = popcount(ENTRY conditions) − popcount(EXIT conditions), computed signed in WIDTH+4 bits.
  - New COUNT = clamp(COUNT+net, 0, MAX_COUNT).
  - SAT_ERR=1 iff the clamp changed the value.
  - Simultaneous entry and exit on different doors cancel, with no SAT_ERR even when FULL or EMPTY.
  - COUNT wrap-around never occurs.
- FULL and EMPTY are registered and consistent with COUNT in every cycle.

## Timing
- A raw change stable for ≥FILTER+2 cycles is accepted exactly FILTER+2 edges after it is first sampled.
- ENTRY_EVT/EXIT_EVT, the COUNT update, FULL/EMPTY and SAT_ERR all assert on the edge after the accepted pair becomes 00 from EN3/EX3.
  - Raw final release to COUNT change: FILTER+3 cycles.
- Pulses last exactly one cycle; each door can produce at most one event per cycle.
- Reset asserted mid-passage: immediate return to reset values; a partial sequence is never completed after reset release.
- Raw glitches shorter than FILTER+1 cycles (after synchronisation) never reach the FSM.

## Test plan
- **Single entry:** Reset, then drive door 0 through 10,11,01,00 with each step held 6 cycles.
  - Required: ENTRY_EVT[0] pulses once, COUNT 0→1, EMPTY 1→0, latency FILTER+3 after the final 00.
- **Entries then exits:** Seven entries on door 0, then seven exits (01,11,10,00).
  - Required: COUNT peaks at 7, returns to 0, EMPTY=1, SAT_ERR never asserted.
- **Saturation:** Sixteen entries with MAX_COUNT=15.
  - Required: COUNT holds 15, FULL=1, the 16th event pulses both ENTRY_EVT and SAT_ERR.
  - From COUNT=0, one exit: COUNT stays 0, SAT_ERR pulses.
- **Abort and backtrack:**
  - Sequence 10,11,10,00: no event, COUNT unchanged.
  - Sequence 10,11,01,11,01,00: one entry.
  - Sequence 10,01,00: no event.
- **Simultaneous doors and glitch rejection:**
  - At COUNT=15, door 0 entry and door 1 exit complete in the same cycle: COUNT stays 15, no SAT_ERR.
  - A 1-cycle raw pulse on SENS_A[1]: no FSM change.
- **Reset mid-passage:** Reset asserted while door 0 is in EN3, then released; drive 00.
  - Required: no ENTRY_EVT, COUNT=0, all outputs at reset values while RST=1.
